// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter and sequencer between the instruction
// cache (port 0), the data cache (port 1) and the shared word RAM.
// The RAM only acts when its command changes, so the arbiter keeps a shadow
// of the last command the RAM completed. A request identical to that shadow
// is answered locally. After reset the RAM's latched command is unknown, so
// the first access is preceded by a deliberately different "prime" command.
module ram_arbiter #(
    parameter int RAM_SIZE = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        we0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    output logic        ack0,
    output logic        err0,
    output logic [31:0] rdata0,
    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    output logic        ack1,
    output logic        err1,
    output logic [31:0] rdata1,
    output logic [31:0] ram_address,
    output logic [31:0] ram_data,
    output logic        ram_write,
    input  logic        ram_response,
    input  logic [31:0] ram_out
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRIME  = 3'd1,
        ISSUE  = 3'd2,
        EXEC   = 3'd3,
        BYPASS = 3'd4,
        DONE   = 3'd5
    } state_t;

    // The RAM decodes addresses modulo its depth, so aliases must compare equal.
    function automatic logic [31:0] wrap_addr(input logic [31:0] a);
        return a % 32'(RAM_SIZE);
    endfunction

    state_t      state;
    state_t      state_n;

    // gnt is the port currently being served and, once idle, the port served
    // last; it resets to 1 so that port 0 wins the first tie.
    logic        gnt;
    logic        wait_cnt;
    logic        seen_resp;
    logic        err_flag;
    logic        sh_valid;

    // Effective command captured at accept; replayed after a prime.
    logic [31:0] cmd_addr;
    logic [31:0] cmd_data;
    logic        cmd_write;

    // Last command completed by a full RAM handshake.
    logic [31:0] sh_addr;
    logic [31:0] sh_data;
    logic        sh_write;

    // Arbitration and effective-command decode.
    logic        arb_any;
    logic        arb_sel;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [31:0] eff_data;
    logic        shadow_hit;

    // FSM strobes.
    logic        accept;
    logic        ld_eff;
    logic        ld_prime;
    logic        ld_cmd;
    logic        wait_inc;
    logic        prime_seen;
    logic        err_set;
    logic        exec_done;
    logic        byp_done;
    logic        ack_fire;

    assign arb_any   = req0 | req1;
    // On a tie the port not granted last wins; otherwise whoever is asking.
    assign arb_sel   = (req0 & req1) ? ~gnt : req1;
    assign sel_we    = arb_sel ? we1    : we0;
    assign sel_addr  = arb_sel ? addr1  : addr0;
    assign sel_wdata = arb_sel ? wdata1 : wdata0;
    // Reads carry the current data bus so a repeated read is an unchanged command.
    assign eff_data  = sel_we ? sel_wdata : ram_data;
    assign shadow_hit = sh_valid
                        && (wrap_addr(sel_addr) == wrap_addr(sh_addr))
                        && (eff_data == sh_data)
                        && (sel_we == sh_write);

    // Next-state logic and per-cycle action strobes.
    always_comb begin
        state_n    = state;
        accept     = 1'b0;
        ld_eff     = 1'b0;
        ld_prime   = 1'b0;
        ld_cmd     = 1'b0;
        wait_inc   = 1'b0;
        prime_seen = 1'b0;
        err_set    = 1'b0;
        exec_done  = 1'b0;
        byp_done   = 1'b0;
        ack_fire   = 1'b0;
        case (state)
            IDLE: begin
                if (arb_any) begin
                    accept = 1'b1;
                    if (shadow_hit) begin
                        state_n = BYPASS;
                    end else if (!sh_valid) begin
                        ld_prime = 1'b1;
                        state_n  = PRIME;
                    end else begin
                        ld_eff  = 1'b1;
                        state_n = ISSUE;
                    end
                end
            end
            PRIME: begin
                // A missing response means the prime already matched the
                // RAM latch; the real command differs from it either way.
                if (!seen_resp) begin
                    if (ram_response) begin
                        prime_seen = 1'b1;
                    end else if (wait_cnt) begin
                        ld_cmd  = 1'b1;
                        state_n = ISSUE;
                    end else begin
                        wait_inc = 1'b1;
                    end
                end else if (!ram_response) begin
                    ld_cmd  = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (ram_response) begin
                    state_n = EXEC;
                end else if (wait_cnt) begin
                    err_set = 1'b1;
                    state_n = DONE;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            EXEC: begin
                if (!ram_response) begin
                    exec_done = 1'b1;
                    state_n   = DONE;
                end
            end
            BYPASS: begin
                byp_done = 1'b1;
                state_n  = DONE;
            end
            DONE: begin
                ack_fire = 1'b1;
                state_n  = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, grant, handshake tracking, RAM command and requester outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gnt         <= 1'b1;
            wait_cnt    <= 1'b0;
            seen_resp   <= 1'b0;
            err_flag    <= 1'b0;
            sh_valid    <= 1'b0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            err0        <= 1'b0;
            err1        <= 1'b0;
            rdata0      <= 32'd0;
            rdata1      <= 32'd0;
            ram_address <= 32'd0;
            ram_data    <= 32'd0;
            ram_write   <= 1'b0;
        end else begin
            state <= state_n;

            ack0 <= ack_fire & ~gnt;
            ack1 <= ack_fire &  gnt;
            err0 <= ack_fire & ~gnt & err_flag;
            err1 <= ack_fire &  gnt & err_flag;

            if (accept) begin
                gnt      <= arb_sel;
                err_flag <= 1'b0;
            end
            if (err_set) begin
                err_flag <= 1'b1;
            end

            // Every fresh drive restarts the response watch.
            if (ld_eff || ld_prime || ld_cmd) begin
                wait_cnt  <= 1'b0;
                seen_resp <= 1'b0;
            end else begin
                if (wait_inc) begin
                    wait_cnt <= 1'b1;
                end
                if (prime_seen) begin
                    seen_resp <= 1'b1;
                end
            end

            // Inverted data guarantees the prime differs from whatever the
            // bus held, and hence from the real read that follows.
            if (ld_prime) begin
                ram_address <= sel_addr;
                ram_data    <= ~ram_data;
                ram_write   <= 1'b0;
            end
            if (ld_eff) begin
                ram_address <= sel_addr;
                ram_data    <= eff_data;
                ram_write   <= sel_we;
            end
            if (ld_cmd) begin
                ram_address <= cmd_addr;
                ram_data    <= cmd_data;
                ram_write   <= cmd_write;
            end

            if ((exec_done || byp_done) && !cmd_write) begin
                if (gnt) begin
                    rdata1 <= ram_out;
                end else begin
                    rdata0 <= ram_out;
                end
            end

            if (exec_done) begin
                sh_valid <= 1'b1;
            end
        end
    end

    // Command capture at accept and shadow update on handshake completion.
    always_ff @(posedge clk) begin
        if (accept) begin
            cmd_addr  <= sel_addr;
            cmd_data  <= eff_data;
            cmd_write <= sel_we;
        end
        if (exec_done) begin
            sh_addr  <= ram_address;
            sh_data  <= ram_data;
            sh_write <= ram_write;
        end
    end

endmodule
